spi_input_frontend: RTL and testbench
=====================================

# spi_input_frontend

Conditions the raw asynchronous SPI pins (SCLK, CS, MOSI) into clean, `clk`-domain signals for the SPI memory control FSM and shift register. Each pin goes through:
- a two-flop synchronizer,
- a counter-based glitch filter,
- an edge detector.

A frame tracker then counts filtered SCLK rising edges while CS is asserted, and reports byte boundaries and truncated frames. All outputs are registered in the `clk` domain.

## Interface
- `WAIT_TIME`, 3: number of consecutive `clk` cycles a synchronized input must differ from its filtered value before the change is accepted (1..15).
- `COUNTER_WIDTH`, 4: width of each filter counter; must hold `WAIT_TIME`.

- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset; synchronous and active-low.
- `sclk_in` in 1: raw SPI serial clock pin.
- `cs_in` in 1: raw SPI chip select pin, active-low.
- `mosi_in` in 1: raw SPI MOSI pin.
- `sclk` out 1: filtered SCLK level.
- `cs` out 1: filtered CS level.
- `mosi` out 1: filtered MOSI level.
- `sclk_rise` out 1: one-cycle pulse when filtered `sclk` goes 0→1.
- `sclk_fall` out 1: one-cycle pulse when filtered `sclk` goes 1→0.
- `cs_fall` out 1: one-cycle pulse when filtered `cs` goes 1→0 (frame start).
- `cs_rise` out 1: one-cycle pulse when filtered `cs` goes 0→1 (frame end).
- `bit_count` out 4: number of SCLK rising edges in the current byte, 0..7.
- `byte_done` out 1: one-cycle pulse when the 8th SCLK rise of a byte is taken.
- `frame_error` out 1: sticky; set when CS deasserts mid-byte.

## Operation
- **Channel structure:** three identical channels (SCLK, CS, MOSI). Each has `sync1`→`sync2` flops, a filter counter `cnt`, a filtered register `out`, and rise/fall pulse registers.
- **Filter rule, per `clk` edge, in priority order:**
  - If `sync2 == out`: `cnt <= 0`.
  - Else if `cnt == WAIT_TIME`: `out <= sync2`, `cnt <= 0`, and pulse the rise or fall output according to the new value.
  - Else: `cnt <= cnt + 1`.
- **Glitch rejection:** any `sync2` excursion lasting ≤ `WAIT_TIME` cycles is rejected and produces no pulse.
- **Pulse width:** edge pulses are registered and high for exactly one cycle. They are asserted in the same cycle the new `out` value first appears.
- **Frame tracker**, evaluated each cycle on the filtered signals:
  - `cs_fall`: `bit_count <= 0`, `frame_error <= 0`.
  - `cs_rise`: if `bit_count != 0`, set `frame_error <= 1`; then `bit_count <= 0`.
  - `sclk_rise` while `cs == 0` and no `cs_rise`:
    - If `bit_count == 7`: `bit_count <= 0`, `byte_done <= 1`.
    - Else: `bit_count <= bit_count + 1`.
  - `sclk_rise` while `cs == 1`: ignored.
  - `byte_done` is otherwise 0.
- **Simultaneous events:**
  - `cs_rise` and `sclk_rise` in the same cycle: `cs_rise` wins. The SCLK edge is discarded and `frame_error` uses the `bit_count` value before the discarded edge.
  - `cs_fall` and `sclk_rise` in the same cycle: `cs_fall` wins and `bit_count` becomes 0. That SCLK edge is not counted; SPI mode 0 guarantees CS setup before the first SCLK.
- **Wrap-around:** `bit_count` is 3 bits of value padded to 4; it never exceeds 7. Multi-byte frames produce one `byte_done` per 8 rises.

## Timing
- **Reset values** (`rst_n` low at a `clk` edge):
  - `sync1`/`sync2`/`out`: SCLK=0, CS=1, MOSI=0.
  - All `cnt` = 0.
  - All pulses = 0, `bit_count` = 0, `byte_done` = 0, `frame_error` = 0.
- **Reset mid-operation:** every output takes its reset value at that edge. Any frame in progress is abandoned with no `frame_error`.
- **Latency:** a pin change captured by `sync1` at edge E0 appears on `out` and its pulse at edge E0+`WAIT_TIME`+2 (5 cycles with default).
- **Frame tracker latency:** `bit_count`/`byte_done`/`frame_error` update one cycle after the filtered pulse that causes them.
- **Minimum SCLK half-period:** `WAIT_TIME`+1 `clk` cycles. Shorter half-periods are filtered away by design.
- **MOSI stability:** MOSI filtering latency equals SCLK latency, so a MOSI value stable from half a period before a raw SCLK rise is valid on `mosi` when `sclk_rise` fires.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with pins toggling → `sclk`=0, `cs`=1, `mosi`=0, all pulses and counters 0. Release, then hold `cs_in`=0 → `cs`=0 and `cs_fall` asserted exactly 5 cycles after capture.
- **Glitch rejection:** pulse `sclk_in` high for 3 cycles → no `sclk_rise`, `sclk` stays 0. Pulse high for 5 cycles → `sclk_rise` once, then `sclk_fall` once.
- **Full byte:** `cs_in`=0, then 8 SCLK periods of 10 cycles each → `bit_count` steps 1..7, wraps to 0, `byte_done` high one cycle, `frame_error`=0. 16 periods → two `byte_done` pulses.
- **Truncated frame:** 5 SCLK rises, then `cs_in`=1 → `frame_error`=1 and `bit_count`=0. Error persists until the next `cs_fall` clears it.
- **Simultaneous events:**
  - Align the raw CS and SCLK rises so `cs_rise` and `sclk_rise` coincide with `bit_count`=7 → no `byte_done`, `frame_error`=1.
  - Force `rst_n` low mid-byte (`bit_count`=4) → all outputs return to reset values at that edge.
- **Idle CS:** SCLK toggles while `cs_in`=1 → `sclk_rise`/`sclk_fall` pulse normally, `bit_count` stays 0, no `byte_done`.

Source files
------------

// File: rtl/spi_input_frontend.sv
// SPI pin conditioning: per-pin two-flop synchronizer, counter glitch filter and
// edge detector, followed by a frame tracker counting SCLK rises inside a CS frame.
module spi_input_frontend #(
    parameter int WAIT_TIME     = 3,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       cs_in,
    input  logic       mosi_in,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic [3:0] bit_count,
    output logic       byte_done,
    output logic       frame_error
);

    localparam int CH_SCLK = 0;
    localparam int CH_CS   = 1;
    localparam int CH_MOSI = 2;
    // Idle pin levels per channel: CS deasserted high, SCLK and MOSI low.
    localparam logic [2:0] IDLE_LEVEL = 3'b010;
    localparam logic [COUNTER_WIDTH-1:0] WAIT_COUNT = COUNTER_WIDTH'(WAIT_TIME);

    logic [2:0] raw;
    logic [2:0] level;
    logic [2:0] rise;
    logic [2:0] fall;

    assign raw = {mosi_in, cs_in, sclk_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic                     sync1_reg;
            logic                     sync2_reg;
            logic                     out_reg;
            logic                     rise_reg;
            logic                     fall_reg;
            logic [COUNTER_WIDTH-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg <= IDLE_LEVEL[gi];
                    sync2_reg <= IDLE_LEVEL[gi];
                    out_reg   <= IDLE_LEVEL[gi];
                    cnt_reg   <= '0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    if (sync2_reg == out_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == WAIT_COUNT) begin
                        // Level held long enough: accept it and flag the edge with it.
                        out_reg  <= sync2_reg;
                        cnt_reg  <= '0;
                        rise_reg <= sync2_reg;
                        fall_reg <= ~sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign level[gi] = out_reg;
            assign rise[gi]  = rise_reg;
            assign fall[gi]  = fall_reg;
        end
    endgenerate

    assign sclk      = level[CH_SCLK];
    assign cs        = level[CH_CS];
    assign mosi      = level[CH_MOSI];
    assign sclk_rise = rise[CH_SCLK];
    assign sclk_fall = fall[CH_SCLK];
    assign cs_rise   = rise[CH_CS];
    assign cs_fall   = fall[CH_CS];

    logic [2:0] bit_count_reg;
    logic       byte_done_reg;
    logic       frame_error_reg;

    // Frame events take priority over a coincident SCLK edge, which is then dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_count_reg   <= '0;
            byte_done_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            byte_done_reg <= 1'b0;
            if (cs_fall) begin
                bit_count_reg   <= '0;
                frame_error_reg <= 1'b0;
            end else if (cs_rise) begin
                if (bit_count_reg != 3'd0) begin
                    frame_error_reg <= 1'b1;
                end
                bit_count_reg <= '0;
            end else if (sclk_rise && !cs) begin
                if (bit_count_reg == 3'd7) begin
                    bit_count_reg <= '0;
                    byte_done_reg <= 1'b1;
                end else begin
                    bit_count_reg <= bit_count_reg + 3'd1;
                end
            end
        end
    end

    assign bit_count   = {1'b0, bit_count_reg};
    assign byte_done   = byte_done_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_spi_input_frontend.sv
// Directed bench for spi_input_frontend: reset, filter latency, glitch rejection,
// byte counting with MOSI capture, truncated frames and coincident events.
module tb_spi_input_frontend;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_in;
    logic       cs_in;
    logic       mosi_in;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;
    logic [3:0] bit_count;
    logic       byte_done;
    logic       frame_error;

    int total  = 0;
    int passed = 0;

    int         n_sclk_rise = 0;
    int         n_sclk_fall = 0;
    int         n_byte      = 0;
    logic [7:0] shift_reg   = 8'h00;

    spi_input_frontend #(
        .WAIT_TIME     (3),
        .COUNTER_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_in     (sclk_in),
        .cs_in       (cs_in),
        .mosi_in     (mosi_in),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .cs_fall     (cs_fall),
        .cs_rise     (cs_rise),
        .bit_count   (bit_count),
        .byte_done   (byte_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Pulse counters and a MOSI capture register, sampled mid-cycle.
    always @(negedge clk) begin
        if (sclk_rise === 1'b1) begin
            n_sclk_rise <= n_sclk_rise + 1;
            shift_reg   <= {shift_reg[6:0], mosi};
        end
        if (sclk_fall === 1'b1) n_sclk_fall <= n_sclk_fall + 1;
        if (byte_done === 1'b1) n_byte <= n_byte + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 10-cycle SCLK period starting high; MOSI moves on the falling half.
    task automatic sclk_period(input logic next_mosi);
        sclk_in = 1'b1;
        step(5);
        sclk_in = 1'b0;
        mosi_in = next_mosi;
        step(5);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sclk"}, {15'd0, sclk}, 16'd0);
        check({tag, "_cs"}, {15'd0, cs}, 16'd1);
        check({tag, "_mosi"}, {15'd0, mosi}, 16'd0);
        check({tag, "_pulses"}, {12'd0, sclk_rise, sclk_fall, cs_rise, cs_fall}, 16'd0);
        check({tag, "_bit_count"}, {12'd0, bit_count}, 16'd0);
        check({tag, "_byte_done"}, {15'd0, byte_done}, 16'd0);
        check({tag, "_frame_error"}, {15'd0, frame_error}, 16'd0);
    endtask

    initial begin
        int          base_rise;
        int          base_fall;
        int          base_byte;
        logic [16:0] stream;

        // Reset held while the pins toggle.
        rst_n   = 1'b0;
        sclk_in = 1'b0;
        cs_in   = 1'b1;
        mosi_in = 1'b0;
        step(1);
        sclk_in = 1'b1;
        cs_in   = 1'b0;
        mosi_in = 1'b1;
        step(1);
        sclk_in = 1'b0;
        cs_in   = 1'b1;
        mosi_in = 1'b0;
        step(1);
        check_reset_state("reset");
        rst_n = 1'b1;
        step(8);

        // CS filter latency: cs_fall appears exactly 5 edges after capture.
        cs_in = 1'b0;
        step(5);
        check("cs_before_latency", {15'd0, cs}, 16'd1);
        check("cs_fall_early", {15'd0, cs_fall}, 16'd0);
        step(1);
        check("cs_after_latency", {15'd0, cs}, 16'd0);
        check("cs_fall_pulse", {15'd0, cs_fall}, 16'd1);
        step(1);
        check("cs_fall_width", {15'd0, cs_fall}, 16'd0);
        cs_in = 1'b1;
        step(8);
        check("empty_frame_error", {15'd0, frame_error}, 16'd0);

        // Glitch rejection: 3-cycle pulse dropped, 5-cycle pulse accepted.
        base_rise = n_sclk_rise;
        base_fall = n_sclk_fall;
        sclk_in = 1'b1;
        step(3);
        sclk_in = 1'b0;
        step(8);
        check("glitch_rise_count", 16'(n_sclk_rise - base_rise), 16'd0);
        check("glitch_sclk_level", {15'd0, sclk}, 16'd0);
        sclk_in = 1'b1;
        step(5);
        sclk_in = 1'b0;
        step(8);
        check("long_pulse_rises", 16'(n_sclk_rise - base_rise), 16'd1);
        check("long_pulse_falls", 16'(n_sclk_fall - base_fall), 16'd1);

        // Two-byte frame 0xA5, 0x3C, MSB first.
        stream    = {16'hA53C, 1'b0};
        base_byte = n_byte;
        cs_in     = 1'b0;
        mosi_in   = stream[16];
        step(8);
        for (int i = 0; i < 16; i++) begin
            sclk_period(stream[15-i]);
            check($sformatf("frame_bit_count_%0d", i), {12'd0, bit_count}, 16'((i + 1) % 8));
            if (i == 7) begin
                check("first_byte_done", 16'(n_byte - base_byte), 16'd1);
                check("first_byte_data", {8'd0, shift_reg}, 16'h00A5);
            end
        end
        check("second_byte_done", 16'(n_byte - base_byte), 16'd2);
        check("second_byte_data", {8'd0, shift_reg}, 16'h003C);
        cs_in = 1'b1;
        step(8);
        check("full_frame_error", {15'd0, frame_error}, 16'd0);

        // Truncated frame: 5 rises then CS released.
        cs_in = 1'b0;
        step(8);
        for (int i = 0; i < 5; i++) sclk_period(1'b0);
        check("trunc_bit_count", {12'd0, bit_count}, 16'd5);
        cs_in = 1'b1;
        step(8);
        check("trunc_frame_error", {15'd0, frame_error}, 16'd1);
        check("trunc_bit_count_clr", {12'd0, bit_count}, 16'd0);
        step(20);
        check("trunc_error_sticky", {15'd0, frame_error}, 16'd1);
        cs_in = 1'b0;
        step(8);
        check("error_cleared_by_cs_fall", {15'd0, frame_error}, 16'd0);
        cs_in = 1'b1;
        step(8);

        // CS and SCLK rise together with bit_count at 7.
        cs_in = 1'b0;
        step(8);
        for (int i = 0; i < 7; i++) sclk_period(1'b0);
        check("coincide_bit_count", {12'd0, bit_count}, 16'd7);
        base_byte = n_byte;
        sclk_in = 1'b1;
        cs_in   = 1'b1;
        step(5);
        sclk_in = 1'b0;
        step(8);
        check("coincide_no_byte_done", 16'(n_byte - base_byte), 16'd0);
        check("coincide_frame_error", {15'd0, frame_error}, 16'd1);
        check("coincide_bit_count_clr", {12'd0, bit_count}, 16'd0);

        // Reset in the middle of a byte.
        cs_in   = 1'b0;
        mosi_in = 1'b1;
        step(8);
        for (int i = 0; i < 4; i++) sclk_period(1'b1);
        check("midreset_bit_count", {12'd0, bit_count}, 16'd4);
        check("midreset_mosi_before", {15'd0, mosi}, 16'd1);
        sclk_in = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(1);
        check_reset_state("midreset");
        rst_n   = 1'b1;
        sclk_in = 1'b0;
        cs_in   = 1'b1;
        mosi_in = 1'b0;
        step(10);
        check("midreset_no_error", {15'd0, frame_error}, 16'd0);

        // SCLK activity with CS idle.
        base_rise = n_sclk_rise;
        base_fall = n_sclk_fall;
        base_byte = n_byte;
        for (int i = 0; i < 3; i++) sclk_period(1'b0);
        step(8);
        check("idle_rises", 16'(n_sclk_rise - base_rise), 16'd3);
        check("idle_falls", 16'(n_sclk_fall - base_fall), 16'd3);
        check("idle_bit_count", {12'd0, bit_count}, 16'd0);
        check("idle_no_byte_done", 16'(n_byte - base_byte), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
